keypad_scan_debounce: RTL and testbench

//  Parametrised matrix-keypad scanner, successor to the fixed 4x4 lab keypad path.
//  - Drives one column low at a time and reads active-low rows through a 2-flop synchroniser.
//  - Debounces press and release, locks onto the first key pressed, and emits one key_valid pulse per press.
//  - Optional auto-repeat mode re-emits the held key.
//  - Keeps the last NDIGITS key codes in a history register that feeds the seven-segment mux.

---
 rtl/keypad_scan_debounce.sv | 182 ++++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: one-cold column drive, synchronised active-low rows,
// press/release debounce with first-key lock, optional auto-repeat and key history.
module keypad_scan_debounce #(
    parameter int NROWS        = 4,
    parameter int NCOLS        = 4,
    parameter int SCAN_CYCLES  = 1000,
    parameter int DEBOUNCE     = 50000,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000,
    parameter int NDIGITS      = 2,
    localparam int KW          = $clog2(NROWS * NCOLS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   repeat_en,
    input  logic [NROWS-1:0]       rows,
    output logic [NCOLS-1:0]       cols,
    output logic [KW-1:0]          key_code,
    output logic                   key_valid,
    output logic                   key_held,
    output logic [NDIGITS*KW-1:0]  history
);

    localparam int RW    = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int CW    = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam int SCW   = $clog2(SCAN_CYCLES + 1);
    localparam int DBW   = $clog2(DEBOUNCE + 1);
    localparam int RPMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW   = $clog2(RPMAX + 1);

    typedef enum logic [1:0] {
        S_SCAN       = 2'd0,
        S_PRESS_DB   = 2'd1,
        S_HELD       = 2'd2,
        S_RELEASE_DB = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [NROWS-1:0]       sync1_reg, sync2_reg;
    logic [CW-1:0]          col_idx_reg, col_next;
    logic [RW-1:0]          row_idx_reg, first_row;
    logic [SCW-1:0]         scan_cnt_reg;
    logic [DBW-1:0]         db_cnt_reg;
    logic [RPW-1:0]         rep_cnt_reg;
    logic                   rep_armed_reg;
    logic [KW-1:0]          key_code_reg, new_code, push_code;
    logic                   key_valid_reg;
    logic [NDIGITS*KW-1:0]  history_reg, history_next;
    logic                   any_low, row_low, scan_last, db_last, rep_hit, accept, push;

    // Lowest-index low row wins when several rows are low on the sampled column.
    always_comb begin
        first_row = '0;
        for (int i = NROWS - 1; i >= 0; i--) begin
            if (!sync2_reg[i]) first_row = RW'(i);
        end
    end

    assign any_low   = ~&sync2_reg;
    assign row_low   = ~sync2_reg[row_idx_reg];
    assign scan_last = (scan_cnt_reg == SCW'(SCAN_CYCLES - 1));
    assign db_last   = (db_cnt_reg == DBW'(DEBOUNCE - 1));
    assign rep_hit   = repeat_en && row_low &&
                       (rep_cnt_reg == (rep_armed_reg ? RPW'(REPEAT_RATE - 1) : RPW'(REPEAT_DELAY - 1)));
    assign accept    = (state_reg == S_PRESS_DB) && row_low && db_last;
    assign push      = accept || ((state_reg == S_HELD) && rep_hit);
    assign new_code  = KW'(row_idx_reg) * KW'(NCOLS) + KW'(col_idx_reg);
    assign push_code = accept ? new_code : key_code_reg;
    assign col_next  = (col_idx_reg == CW'(NCOLS - 1)) ? '0 : col_idx_reg + CW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NCOLS; gi++) begin : g_cols
            assign cols[gi] = (col_idx_reg != CW'(gi));
        end
        for (gi = 0; gi < NDIGITS; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign history_next[KW-1:0] = push_code;
            end else begin : g_tail
                assign history_next[gi*KW +: KW] = history_reg[(gi-1)*KW +: KW];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_SCAN;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_SCAN:       if (scan_last && any_low) state_next = S_PRESS_DB;
            S_PRESS_DB:   if (!row_low) state_next = S_SCAN;
                          else if (db_last) state_next = S_HELD;
            S_HELD:       if (!row_low) state_next = S_RELEASE_DB;
            S_RELEASE_DB: if (row_low) state_next = S_HELD;
                          else if (db_last) state_next = S_SCAN;
            default:      state_next = S_SCAN;
        endcase
    end

    always_comb begin
        key_held  = (state_reg == S_HELD) || (state_reg == S_RELEASE_DB);
        key_valid = key_valid_reg;
        key_code  = key_code_reg;
        history   = history_reg;
    end

    // Counters are cleared on every exit from their state, so none can run past its limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg     <= '1;
            sync2_reg     <= '1;
            col_idx_reg   <= '0;
            row_idx_reg   <= '0;
            scan_cnt_reg  <= '0;
            db_cnt_reg    <= '0;
            rep_cnt_reg   <= '0;
            rep_armed_reg <= 1'b0;
            key_code_reg  <= '0;
            key_valid_reg <= 1'b0;
            history_reg   <= '0;
        end else begin
            sync1_reg     <= rows;
            sync2_reg     <= sync1_reg;
            key_valid_reg <= push;
            if (push) begin
                key_code_reg <= push_code;
                history_reg  <= history_next;
            end
            case (state_reg)
                S_SCAN: begin
                    if (scan_last) begin
                        scan_cnt_reg <= '0;
                        if (any_low) begin
                            row_idx_reg <= first_row;
                            db_cnt_reg  <= DBW'(1);
                        end else begin
                            col_idx_reg <= col_next;
                        end
                    end else begin
                        scan_cnt_reg <= scan_cnt_reg + SCW'(1);
                    end
                end
                S_PRESS_DB: begin
                    rep_cnt_reg   <= '0;
                    rep_armed_reg <= 1'b0;
                    if (!row_low || db_last) db_cnt_reg <= '0;
                    else                     db_cnt_reg <= db_cnt_reg + DBW'(1);
                end
                S_HELD: begin
                    if (!row_low) begin
                        db_cnt_reg    <= DBW'(1);
                        rep_cnt_reg   <= '0;
                        rep_armed_reg <= 1'b0;
                    end else if (!repeat_en) begin
                        rep_cnt_reg   <= '0;
                        rep_armed_reg <= 1'b0;
                    end else if (rep_hit) begin
                        rep_cnt_reg   <= '0;
                        rep_armed_reg <= 1'b1;
                    end else begin
                        rep_cnt_reg   <= rep_cnt_reg + RPW'(1);
                    end
                end
                S_RELEASE_DB: begin
                    if (row_low) begin
                        db_cnt_reg <= '0;
                    end else if (db_last) begin
                        db_cnt_reg  <= '0;
                        col_idx_reg <= col_next;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DBW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a simulated key matrix plus a timestamp model
// that predicts detection, acceptance, repeat and release times for each press.
module tb_keypad_scan_debounce;
    localparam int NR = 4, NC = 4, SC = 4, DB = 8, RD = 64, RR = 16, ND = 2, KW = 4;
    localparam int LOGN = 32768;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              repeat_en = 1'b0;
    logic [NR-1:0]     rows;
    logic [NC-1:0]     cols;
    logic [KW-1:0]     key_code;
    logic              key_valid, key_held;
    logic [ND*KW-1:0]  history;
    logic [NR*NC-1:0]  pressed = '0;

    int cyc = 0;
    int vectors = 0, miscompares = 0;
    int t0, c0;
    logic [ND*KW-1:0] model_hist;
    int pulse_t[$];
    int pulse_c[$];
    bit held_log[LOGN];
    logic [NC-1:0] cols_log[LOGN];

    keypad_scan_debounce #(
        .NROWS(NR), .NCOLS(NC), .SCAN_CYCLES(SC), .DEBOUNCE(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .NDIGITS(ND)
    ) dut (
        .clk(clk), .reset(reset), .repeat_en(repeat_en), .rows(rows), .cols(cols),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .history(history)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive switch matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows = '1;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (pressed[r*NC+c] && (cols[c] === 1'b0)) rows[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            held_log[cyc] <= key_held;
            cols_log[cyc] <= cols;
        end
        if (key_valid === 1'b1) begin
            pulse_t.push_back(cyc);
            pulse_c.push_back(int'(key_code));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void push_hist(input int code);
        logic [KW-1:0] k;
        k = KW'(code);
        model_hist = {model_hist[(ND-1)*KW-1:0], k};
    endfunction

    // Columns are visited in order from (t0, c0) every SC cycles; a slot sees the key
    // if it was already pressed two cycles (synchroniser depth) before the slot's last cycle.
    function automatic int detect(input int key, input int tp);
        int c;
        c = key % NC;
        for (int n = 0; n < 4096; n++)
            if (((c0 + n) % NC == c) && (t0 + n*SC + SC - 3 >= tp)) return t0 + n*SC + SC - 1;
        return -1;
    endfunction

    task automatic run_press(input int key, input int gap, input int hold, input bit rep, input int extra);
        int tp, tdet, acc, tr, rel;
        int exp_t[$];
        tick();
        wait_to(t0);
        repeat (gap) tick();
        pulse_t.delete();
        pulse_c.delete();
        repeat_en = rep;
        tp = cyc;
        pressed[key] = 1'b1;
        tdet = detect(key, tp);
        acc  = tdet + DB;
        tr   = tp + hold;
        rel  = tr + 2 + DB;
        exp_t.push_back(acc);
        if (rep)
            for (int p = acc + RD; p <= tr + 2; p += RR) exp_t.push_back(p);
        if (extra >= 0) begin
            wait_to(acc + 4);
            pressed[extra] = 1'b1;
            wait_to(tr - 10);
            pressed[extra] = 1'b0;
        end
        wait_to(tr);
        pressed[key] = 1'b0;
        wait_to(rel + 2);
        @(negedge clk);
        check($sformatf("k%0d_npulse", key), pulse_t.size(), exp_t.size());
        for (int i = 0; i < exp_t.size() && i < pulse_t.size(); i++) begin
            check($sformatf("k%0d_pulse%0d_time", key, i), pulse_t[i], exp_t[i]);
            check($sformatf("k%0d_pulse%0d_code", key, i), pulse_c[i], key);
        end
        for (int i = 0; i < exp_t.size(); i++) push_hist(key);
        check($sformatf("k%0d_held_before", key), held_log[acc-1], 0);
        check($sformatf("k%0d_held_accept", key), held_log[acc], 1);
        check($sformatf("k%0d_held_last", key), held_log[rel-1], 1);
        check($sformatf("k%0d_held_released", key), held_log[rel], 0);
        check($sformatf("k%0d_key_code", key), key_code, key);
        check($sformatf("k%0d_history", key), history, model_hist);
        $display("press key=%0d hold=%0d repeat=%0d extra=%0d accept@%0d pulses=%0d/%0d history=%h",
                 key, hold, rep, extra, acc, pulse_t.size(), exp_t.size(), history);
        t0 = rel;
        c0 = (key % NC + 1) % NC;
        repeat_en = 1'b0;
    endtask

    initial begin
        int bad, tr, rel, tp, tdet, acc, rkey, rhold, rgap;
        bit rrep;
        logic [NC-1:0] one, expc;
        one = 1;

        // Reset and idle scanning
        repeat (3) tick();
        reset = 1'b0;
        t0 = cyc;
        c0 = 0;
        model_hist = '0;
        @(negedge clk);
        check("rst_cols", cols, 4'b1110);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_held", key_held, 0);
        check("rst_history", history, 0);
        wait_to(t0 + 100);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            expc = ~(one << ((i / SC) % NC));
            if (cols_log[t0 + i] !== expc) bad++;
        end
        check("idle_cols_bad_cycles", bad, 0);
        check("idle_pulses", pulse_t.size(), 0);
        check("idle_history", history, 0);
        $display("idle scan 100 cycles: column errors=%0d pulses=%0d", bad, pulse_t.size());

        // Single key 2 (row0, col2)
        run_press(2, 0, 40, 1'b0, -1);

        // Bouncing key 5, then a stable press
        tick();
        wait_to(t0);
        pulse_t.delete();
        pulse_c.delete();
        for (int i = 0; i < 5; i++) begin
            pressed[5] = 1'b1;
            repeat (3) tick();
            pressed[5] = 1'b0;
            repeat (2) tick();
        end
        check("bounce_no_pulse", pulse_t.size(), 0);
        pressed[5] = 1'b1;
        repeat (40) tick();
        tr = cyc;
        pressed[5] = 1'b0;
        rel = tr + 2 + DB;
        wait_to(rel + 2);
        @(negedge clk);
        check("bounce_npulse", pulse_t.size(), 1);
        if (pulse_c.size() > 0) check("bounce_code", pulse_c[0], 5);
        push_hist(5);
        check("bounce_key_code", key_code, 5);
        check("bounce_held_last", held_log[rel-1], 1);
        check("bounce_held_released", held_log[rel], 0);
        check("bounce_history", history, model_hist);
        $display("bounce key=5 pulses=%0d history=%h", pulse_t.size(), history);
        t0 = rel;
        c0 = 2;

        // History shifting
        run_press(6, 3, 50, 1'b0, -1);
        run_press(13, 5, 50, 1'b0, -1);
        check("hist_6_13", history, 8'h6D);
        run_press(0, 2, 50, 1'b0, -1);
        check("hist_13_0", history, 8'hD0);

        // Auto-repeat on key 6 with key 11 pressed while locked
        run_press(6, 1, 120, 1'b1, 11);

        // Reset while held
        tick();
        wait_to(t0);
        pulse_t.delete();
        pulse_c.delete();
        tp = cyc;
        pressed[3] = 1'b1;
        tdet = detect(3, tp);
        acc = tdet + DB;
        wait_to(acc + 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        t0 = cyc;
        c0 = 0;
        model_hist = '0;
        @(negedge clk);
        check("hreset_accepted_before", pulse_t.size(), 1);
        check("hreset_cols", cols, 4'b1110);
        check("hreset_key_code", key_code, 0);
        check("hreset_key_valid", key_valid, 0);
        check("hreset_key_held", key_held, 0);
        check("hreset_history", history, 0);
        pulse_t.delete();
        pulse_c.delete();
        repeat (3) tick();
        pressed[3] = 1'b0;
        repeat (60) tick();
        @(negedge clk);
        check("hreset_release_no_pulse", pulse_t.size(), 0);
        check("hreset_held_after", key_held, 0);
        $display("reset in held: key=3 accept@%0d pulses after reset=%0d", acc, pulse_t.size());

        // Randomised presses
        for (int n = 0; n < 12; n++) begin
            rkey  = $urandom_range(0, NR*NC - 1);
            rgap  = $urandom_range(0, 20);
            rhold = $urandom_range(30, 160);
            rrep  = 1'($urandom_range(0, 1));
            run_press(rkey, rgap, rhold, rrep, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
